ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, and so on) to the keyboard over the same open-drain clock/data pair that the existing ps2keyboard receiver listens on. It sits next to ps2keyboard in the 50 MHz domain and is driven by a CPU-visible command register. tx_busy tells the top level to ignore received bytes while a transfer is in progress.

Parameters:
INHIBIT_CYC, 5000, clock-low inhibit time in clock50 cycles (100 us at 50 MHz)
TIMEOUT_CYC, 750000, max cycles between device clock edges before abort (15 ms)
FILTER_LEN, 8, consecutive equal samples needed to accept a line level change

Ports:
clock50  input  1  50 MHz system clock
reset_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to transmit, latched on accept
tx_start  input  1  request; accepted only when tx_busy=0
tx_busy  output  1  high from accept until done/error pulse
tx_done  output  1  1-cycle pulse, transfer finished (ACK or error)
tx_error  output  1  1-cycle pulse coincident with tx_done: no ACK or timeout
ps2_clk_in  input  1  PS2_CLK pin level (asynchronous)
ps2_dat_in  input  1  PS2_DAT pin level (asynchronous)
ps2_clk_oe  output  1  1 = drive PS2_CLK low; 0 = release (Z)
ps2_dat_oe  output  1  1 = drive PS2_DAT low; 0 = release (Z)

Behaviour:
- Reset (async, reset_n=0): state IDLE; tx_busy=0, tx_done=0, tx_error=0, ps2_clk_oe=0, ps2_dat_oe=0, counters 0. A reset during a transfer releases both lines immediately, with no done pulse.
- Input conditioning: 2-flop synchroniser, then deglitch. The filtered level changes only after FILTER_LEN equal synchronised samples. clk_fall is a 1-cycle pulse on a filtered 1->0 transition.
- Shift frame, LSB first: {stop=1, parity=~^tx_data (odd), data[7:0]}. Start bit is the data-low request.
- IDLE: outputs released. If tx_start=1, latch tx_data, set tx_busy=1, go to INHIBIT. tx_start while busy is ignored, with no queueing.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles, then go to REQ.
- REQ, 1 cycle: ps2_clk_oe=1, ps2_dat_oe=1. Next cycle: ps2_clk_oe=0, data held low, go to SEND with bit index 0.
- SEND: on each clk_fall, set ps2_dat_oe = ~frame[idx] and increment idx.
  - Falls 1-8: data bits 0-7.
  - Fall 9: parity.
  - Fall 10: stop (ps2_dat_oe=0).
  - Then go to ACK.
- ACK: on the next clk_fall, sample filtered data. 0 = ACK ok; 1 = error flag set. Go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock=1 and data=1, then go to DONE.
- DONE, 1 cycle: tx_done=1, tx_error=flag, tx_busy=0 in the following cycle, then IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE, a cycle counter is cleared on every clk_fall. When it reaches TIMEOUT_CYC:
  - release both lines;
  - set the error flag;
  - go to DONE.
- Device holding clock low in IDLE does not block a start. INHIBIT overrides it, and the timeout covers a dead device.
- The counter is wide enough for TIMEOUT_CYC (20 bits at defaults). Arithmetic is unsigned with no wrap: counting saturates at the compare point.

Decomposition:
- Shared package ps2_pkg holds:
  - the state encoding (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE);
  - frame length constant 10;
  - command constants 0xED, 0xF3, 0xF4, 0xFF;
  - ACK/RESEND codes 0xFA and 0xFE, for software use.
- One sub-module, ps2_line_filter (sync + deglitch + fall pulse, parameter FILTER_LEN). It is instantiated twice, for clock and data, and can later be reused by ps2keyboard.

Test Plan:
- tx_data=0xED, tx_start pulse; bus model clocks at 12.5 kHz and ACKs -> ps2_clk_oe=1 for 5000 cycles. Data bits seen at rising edges are 1,0,1,1,0,1,1,1, then parity=1, stop=1. tx_done=1 with tx_error=0, tx_busy falls the next cycle.
- tx_data=0x07 -> parity bit 0 observed. Same handshake completes with tx_error=0.
- Device leaves data high at the ACK fall -> tx_done=1 with tx_error=1, and lines released.
- Device never clocks after REQ -> after 750000 cycles both oe=0, tx_done=tx_error=1, state IDLE.
- Second tx_start during a transfer, plus 3-cycle glitches on ps2_clk_in -> the second request is ignored, the frame is unchanged and exactly one done pulse occurs. Glitches shorter than FILTER_LEN produce no clk_fall.
- reset_n asserted mid-SEND (after 4 bits) -> both oe=0 and tx_busy=0 immediately. A new 0xFF transfer after reset completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM encoding, frame
// geometry, keyboard command bytes and the device response codes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE
    } ps2_state_e;

    // Bits shifted after the start bit: 8 data, odd parity, stop.
    localparam int unsigned FRAME_LEN = 10;

    // Host-to-keyboard command bytes.
    localparam logic [7:0] CMD_SET_LED   = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_ENABLE    = 8'hF4;
    localparam logic [7:0] CMD_RESET     = 8'hFF;

    // Keyboard responses, decoded by software from the receive path.
    localparam logic [7:0] RSP_ACK       = 8'hFA;
    localparam logic [7:0] RSP_RESEND    = 8'hFE;

    // Transmit frame, LSB first: data[7:0], odd parity, stop.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one asynchronous PS/2 pin: 2-flop synchroniser, deglitch that
// only follows a new level after FILTER_LEN equal samples, and a one-cycle
// pulse on each filtered 1->0 transition.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clock50,
    input  logic reset_n,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: count consecutive samples disagreeing with the held level.
    always_comb begin
        sync_d  = {sync_q[0], pin_in};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = level_q & ~level_d;
    end

    // State registers; idle bus level is high, so reset to 1.
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start
// request, shifts one command byte on device clock falls and checks the
// device ACK, with a watchdog against a silent device.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 750000,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic       clock50,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = $clog2(FRAME_LEN);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_V    = CW'(TIMEOUT_CYC);
    localparam logic [IW-1:0] IDX_LAST     = IW'(FRAME_LEN - 1);

    ps2_state_e           state_q, state_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 dat_oe_q, dat_oe_d;

    logic clk_level, clk_fall, dat_level;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock50 (clock50),
        .reset_n (reset_n),
        .pin_in  (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clock50 (clock50),
        .reset_n (reset_n),
        .pin_in  (ps2_dat_in),
        .level   (dat_level),
        .fall    ()
    );

    // Next-state and output logic for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_start) begin
                    frame_d  = build_frame(tx_data);
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_REQ: begin
                clk_oe_d = 1'b0;
                idx_d    = '0;
                cnt_d    = '0;
                state_d  = ST_SEND;
            end

            ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                // Watchdog: restarts on each device clock fall, saturates at the limit.
                if (clk_fall) begin
                    cnt_d = '0;
                end else if (cnt_q != TIMEOUT_V) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (!clk_fall && cnt_q == TIMEOUT_V) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    case (state_q)
                        ST_SEND: begin
                            if (clk_fall) begin
                                dat_oe_d = ~frame_q[idx_q];
                                idx_d    = idx_q + 1'b1;
                                if (idx_q == IDX_LAST) begin
                                    state_d = ST_ACK;
                                end
                            end
                        end
                        ST_ACK: begin
                            if (clk_fall) begin
                                err_d   = dat_level;
                                state_d = ST_WAIT_IDLE;
                            end
                        end
                        default: begin
                            if (clk_level && dat_level) begin
                                done_d  = 1'b1;
                                error_d = err_q;
                                state_d = ST_DONE;
                            end
                        end
                    endcase
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases both lines at once.
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model,
// expected outcomes queued per transfer and checked on each tx_done.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 300;
    localparam int unsigned TMO = 3000;
    localparam int unsigned FLT = 8;
    localparam int unsigned HP  = 100;

    logic       clock50  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #10 clock50 = ~clock50;

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TMO),
        .FILTER_LEN  (FLT)
    ) dut (
        .clock50    (clock50),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    typedef struct {
        logic       err;
        logic       chk_frame;
        logic [9:0] frame;
        logic       tmo;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    logic [9:0] cap_frame = '0;
    int         inh_run = 0, inh_last = 0;
    int         req_run = 0, req_last = 0;
    int         rel_cyc = 0;
    logic       clk_oe_prev = 1'b0;
    logic       busy_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: line-timing bookkeeping and scoreboard pop on every done pulse.
    always @(negedge clock50) begin
        if (busy_chk) begin
            check("busy_after_done", tx_busy, 0);
            busy_chk = 1'b0;
        end
        if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
        else if (inh_run != 0) begin inh_last = inh_run; inh_run = 0; end
        if (ps2_clk_oe && ps2_dat_oe) req_run++;
        else if (req_run != 0) begin req_last = req_run; req_run = 0; end
        if (clk_oe_prev && !ps2_clk_oe && ps2_dat_oe) rel_cyc = 0;
        else rel_cyc++;
        clk_oe_prev = ps2_clk_oe;
        if (tx_error && !tx_done) check("error_without_done", 1, 0);
        if (tx_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_error", tx_error, mon_e.err);
                check("busy_at_done", tx_busy, 1);
                check("clk_oe_at_done", ps2_clk_oe, 0);
                check("dat_oe_at_done", ps2_dat_oe, 0);
                if (mon_e.chk_frame) check("frame", cap_frame, mon_e.frame);
                if (mon_e.tmo) check("timeout_window", (rel_cyc >= TMO && rel_cyc <= TMO + 2), 1);
                busy_chk = 1'b1;
            end
        end
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clock50);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock50);
        tx_start = 1'b0;
    endtask

    // Keyboard model: waits for the start request, clocks the frame in,
    // optionally glitches the clock, ACKs or leaves data high.
    task automatic dev_xfer(input logic ack, input logic glitch, input int unsigned stop_after);
        int unsigned n = 0;
        cap_frame = '0;
        while (!(!ps2_clk_oe && ps2_dat_oe) && n < 3000) begin
            @(negedge clock50);
            n++;
        end
        if (n >= 3000) begin
            check("dev_wait_request", 0, 1);
            return;
        end
        repeat (HP) @(negedge clock50);
        for (int i = 0; i < 10; i++) begin
            if (i == int'(stop_after)) return;
            dev_clk = 1'b0;
            repeat (HP) @(negedge clock50);
            dev_clk = 1'b1;
            cap_frame[i] = ps2_dat_in;
            if (glitch && (i == 2 || i == 5)) begin
                repeat (HP / 2) @(negedge clock50);
                dev_clk = 1'b0;
                repeat (3) @(negedge clock50);
                dev_clk = 1'b1;
                repeat (HP / 2 - 3) @(negedge clock50);
            end else begin
                repeat (HP) @(negedge clock50);
            end
        end
        dev_dat = ack ? 1'b0 : 1'b1;
        repeat (HP) @(negedge clock50);
        dev_clk = 1'b0;
        repeat (HP) @(negedge clock50);
        dev_clk = 1'b1;
        repeat (HP) @(negedge clock50);
        dev_dat = 1'b1;
    endtask

    task automatic wait_done(input int target, input int unsigned budget);
        int unsigned n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clock50);
            n++;
        end
        check("done_seen", done_cnt >= target, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock50);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock50);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        exp_q.push_back('{err: 1'b0, chk_frame: 1'b1, frame: 10'h3ED, tmo: 1'b0});
        fork
            start_tx(CMD_SET_LED);
            dev_xfer(1'b1, 1'b0, 99);
        join
        wait_done(1, 2000);
        check("inhibit_len", inh_last, INH);
        check("req_len", req_last, 1);

        // 0x07: parity 0
        exp_q.push_back('{err: 1'b0, chk_frame: 1'b1, frame: 10'h207, tmo: 1'b0});
        fork
            start_tx(8'h07);
            dev_xfer(1'b1, 1'b0, 99);
        join
        wait_done(2, 2000);

        // 0xF4 with no ACK: parity 0, error expected
        exp_q.push_back('{err: 1'b1, chk_frame: 1'b1, frame: 10'h2F4, tmo: 1'b0});
        fork
            start_tx(CMD_ENABLE);
            dev_xfer(1'b0, 1'b0, 99);
        join
        wait_done(3, 2000);

        // Dead device: watchdog expires after release of the clock
        exp_q.push_back('{err: 1'b1, chk_frame: 1'b0, frame: 10'h000, tmo: 1'b1});
        start_tx(CMD_SET_LED);
        wait_done(4, INH + TMO + 500);
        repeat (3) @(negedge clock50);
        check("tmo_idle_busy", tx_busy, 0);
        check("tmo_idle_clk_oe", ps2_clk_oe, 0);

        // 0xF3 with clock glitches and an ignored second request
        exp_q.push_back('{err: 1'b0, chk_frame: 1'b1, frame: 10'h3F3, tmo: 1'b0});
        fork
            start_tx(CMD_TYPEMATIC);
            dev_xfer(1'b1, 1'b1, 99);
            begin
                repeat (1500) @(negedge clock50);
                start_tx(8'h00);
            end
        join
        wait_done(5, 2000);
        repeat (200) @(negedge clock50);
        check("single_done", done_cnt, 5);

        // Reset after four bits, then a normal 0xFF transfer
        fork
            start_tx(8'hA5);
            dev_xfer(1'b1, 1'b0, 4);
        join
        check("busy_mid_send", tx_busy, 1);
        @(negedge clock50);
        reset_n = 1'b0;
        #1;
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_dat_oe", ps2_dat_oe, 0);
        check("abort_busy", tx_busy, 0);
        repeat (5) @(negedge clock50);
        reset_n = 1'b1;
        repeat (20) @(negedge clock50);
        exp_q.push_back('{err: 1'b0, chk_frame: 1'b1, frame: 10'h3FF, tmo: 1'b0});
        fork
            start_tx(CMD_RESET);
            dev_xfer(1'b1, 1'b0, 99);
        join
        wait_done(6, 2000);
        repeat (50) @(negedge clock50);
        check("final_done_count", done_cnt, 6);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
